vga_capture: RTL and testbench

Receive-side counterpart of the VGA pin generator. It samples the 8-bit TinyVGA PMOD bus (`uo_out` format), recovers line and frame timing from the sync edges, and reconstructs pixel coordinates. It computes a per-frame pixel signature and serves single-pixel probe reads through a 4-phase handshake. It sits in the simulation/self-test harness downstream of the `tt_um_*` VGA output.

---
 rtl/vga_capture.sv | 193 +++++++++++++++++++
 tb/tb_vga_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: receive side of the TinyVGA PMOD bus. Recovers line/frame
// timing from the sync edges, tracks lock, signs each frame and serves
// single-pixel probe reads over a 4-phase req/ack handshake.
module vga_capture #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_START  = 144,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_START  = 35,
  parameter logic        SYNC_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        probe_req,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        probe_ack,
  output logic [5:0]  probe_rgb,
  output logic        probe_oor,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [7:0]  frame_count,
  output logic        err_hlen,
  output logic        err_vlen
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_OFF   = 10'(H_START);
  localparam logic [9:0]  V_OFF   = 10'(V_START);
  localparam logic [10:0] X_LO    = 11'(H_START);
  localparam logic [10:0] X_HI    = 11'(H_START + 640);
  localparam logic [10:0] Y_LO    = 11'(V_START);
  localparam logic [10:0] Y_HI    = 11'(V_START + 480);
  localparam logic [9:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

  logic [7:0]  in_q;
  logic        hs_a_q, hs_b_q, vs_a_q, vs_b_q;
  logic [5:0]  pix_q;
  logic        hs_rise, vs_rise;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        seen_hs_q;
  logic        lost, err_h_now, err_v_now, frame_ok;
  logic        err_seen_q, err_seen_d;
  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        active, probe_hit, req_oor;
  logic [9:0]  pix_x, pix_y;
  logic        fd_d;
  logic        fd_q, errh_q, errv_q;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d, oor_q, oor_d, wait_low_q, wait_low_d;
  logic [5:0]  rgb_q, rgb_d;

  // Sync history resets to "asserted" so a bus parked in the asserted
  // state after reset never produces a spurious assertion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      hs_a_q <= 1'b1;
      hs_b_q <= 1'b1;
      vs_a_q <= 1'b1;
      vs_b_q <= 1'b1;
      pix_q  <= '0;
    end else begin
      in_q   <= vga_in;
      hs_a_q <= in_q[7] ^ SYNC_NEG;
      hs_b_q <= hs_a_q;
      vs_a_q <= in_q[3] ^ SYNC_NEG;
      vs_b_q <= vs_a_q;
      pix_q  <= {in_q[0], in_q[4], in_q[1], in_q[5], in_q[2], in_q[6]};
    end
  end

  assign hs_rise = hs_a_q & ~hs_b_q;
  assign vs_rise = vs_a_q & ~vs_b_q;

  // hcnt_d/vcnt_d are the coordinates of the pixel currently in pix_q;
  // the _q copies hold the previous cycle's values for length checks.
  always_comb begin
    hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
    if (hs_rise) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (hs_rise && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
    if (vs_rise) vcnt_d = '0;
    lost      = (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
    err_h_now = hs_rise && seen_hs_q && (hcnt_q != H_LAST) && !lost;
    err_v_now = vs_rise && (vcnt_q != V_LAST) && !lost;
    frame_ok  = !err_seen_q && !err_h_now && !err_v_now;
    err_seen_d = vs_rise ? 1'b0 : (err_seen_q | err_h_now);
    active = ({1'b0, hcnt_d} >= X_LO) && ({1'b0, hcnt_d} < X_HI) &&
             ({1'b0, vcnt_d} >= Y_LO) && ({1'b0, vcnt_d} < Y_HI);
    pix_x  = hcnt_d - H_OFF;
    pix_y  = vcnt_d - V_OFF;
    // The pixel coinciding with vs_rise belongs to the new frame.
    acc_d  = (vs_rise ? 16'd0 : acc_q) + (active ? {10'd0, pix_q} : 16'd0);
    fd_d   = vs_rise && !lost && (state_q != S_IDLE) && frame_ok;
    sig_d  = fd_d ? acc_q : sig_q;
    cnt_d  = cnt_q + {7'd0, fd_d};
  end

  // Lock FSM next state; lost timing overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (lost) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (vs_rise) state_d = S_TRACK;
        S_TRACK:  if (vs_rise && frame_ok) state_d = S_LOCKED;
        S_LOCKED: if (err_h_now || err_v_now) state_d = S_TRACK;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Probe handshake: serve once, then wait for req to drop.
  always_comb begin
    ack_d      = 1'b0;
    rgb_d      = rgb_q;
    oor_d      = oor_q;
    wait_low_d = wait_low_q;
    req_oor    = (probe_x >= 10'd640) || (probe_y >= 10'd480);
    probe_hit  = active && (pix_x == probe_x) && (pix_y == probe_y);
    if (!probe_req) begin
      wait_low_d = 1'b0;
    end else if (!wait_low_q) begin
      if (req_oor) begin
        ack_d      = 1'b1;
        oor_d      = 1'b1;
        rgb_d      = '0;
        wait_low_d = 1'b1;
      end else if (state_q == S_LOCKED && probe_hit) begin
        ack_d      = 1'b1;
        oor_d      = 1'b0;
        rgb_d      = pix_q;
        wait_low_d = 1'b1;
      end
    end
  end

  // Timing, signature and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      seen_hs_q  <= 1'b0;
      err_seen_q <= 1'b0;
      state_q    <= S_IDLE;
      acc_q      <= '0;
      fd_q       <= 1'b0;
      errh_q     <= 1'b0;
      errv_q     <= 1'b0;
      sig_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      rgb_q      <= '0;
      oor_q      <= 1'b0;
      wait_low_q <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      seen_hs_q  <= seen_hs_q | hs_rise;
      err_seen_q <= err_seen_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      fd_q       <= fd_d;
      errh_q     <= err_h_now;
      errv_q     <= err_v_now;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rgb_q      <= rgb_d;
      oor_q      <= oor_d;
      wait_low_q <= wait_low_d;
    end
  end

  assign probe_ack   = ack_q;
  assign probe_rgb   = rgb_q;
  assign probe_oor   = oor_q;
  assign locked      = (state_q == S_LOCKED);
  assign frame_done  = fd_q;
  assign frame_sig   = sig_q;
  assign frame_count = cnt_q;
  assign err_hlen    = errh_q;
  assign err_vlen    = errv_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunk raster (24x14 totals,
// active window 18x11) so each frame is 336 clocks.
module tb_vga_capture;

  localparam int HT = 24;
  localparam int HS = 6;
  localparam int VT = 14;
  localparam int VS = 3;

  // 198 pixels of 6'h3F = 12474; with one pixel replaced by 6'h24 = 12447.
  localparam logic [15:0] SIG_3F   = 16'h30BA;
  localparam logic [15:0] SIG_SPOT = 16'h309F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_in;
  logic        probe_req;
  logic [9:0]  probe_x, probe_y;
  logic        probe_ack;
  logic [5:0]  probe_rgb;
  logic        probe_oor;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sig;
  logic [7:0]  frame_count;
  logic        err_hlen, err_vlen;

  int n_checks = 0;
  int n_err    = 0;
  int n_fd     = 0;
  int n_eh     = 0;
  int n_ev     = 0;
  int n_ack    = 0;
  int fd_mark;

  vga_capture #(
    .H_TOTAL (HT),
    .H_START (HS),
    .V_TOTAL (VT),
    .V_START (VS),
    .SYNC_NEG(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_in     (vga_in),
    .probe_req  (probe_req),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .probe_ack  (probe_ack),
    .probe_rgb  (probe_rgb),
    .probe_oor  (probe_oor),
    .locked     (locked),
    .frame_done (frame_done),
    .frame_sig  (frame_sig),
    .frame_count(frame_count),
    .err_hlen   (err_hlen),
    .err_vlen   (err_vlen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_fd++;
    if (err_hlen === 1'b1)   n_eh++;
    if (err_vlen === 1'b1)   n_ev++;
    if (probe_ack === 1'b1)  n_ack++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(probe_ack),   32'd0);
    chk({tag, "_rgb"},   32'(probe_rgb),   32'd0);
    chk({tag, "_oor"},   32'(probe_oor),   32'd0);
    chk({tag, "_lock"},  32'(locked),      32'd0);
    chk({tag, "_fd"},    32'(frame_done),  32'd0);
    chk({tag, "_sig"},   32'(frame_sig),   32'd0);
    chk({tag, "_cnt"},   32'(frame_count), 32'd0);
    chk({tag, "_errh"},  32'(err_hlen),    32'd0);
    chk({tag, "_errv"},  32'(err_vlen),    32'd0);
  endtask

  // One frame on the pins: sync asserted (low) for h<2 and for line 0;
  // pixel (5,7) gets 'spot', other active pixels get 'col'.
  task automatic frame(input logic [5:0] col, input logic [5:0] spot,
                       input int nlines, input int short_line);
    logic [5:0] c;
    logic hs, vs;
    int len;
    for (int v = 0; v < nlines; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(negedge clk);
        hs = (h < 2);
        vs = (v == 0);
        if (h >= HS && v >= VS) c = (h - HS == 5 && v - VS == 7) ? spot : col;
        else c = '0;
        vga_in = {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
      end
    end
  endtask

  task automatic probe_in_range(input logic [9:0] px, input logic [9:0] py,
                                input logic [5:0] exp_rgb);
    logic got;
    @(negedge clk);
    probe_x = px;
    probe_y = py;
    probe_req = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (probe_ack === 1'b1) got = 1'b1;
    end
    chk("probe_ack_seen", 32'(got), 32'd1);
    chk("probe_rgb", 32'(probe_rgb), 32'(exp_rgb));
    chk("probe_oor0", 32'(probe_oor), 32'd0);
    probe_req = 1'b0;
    @(negedge clk);
    chk("probe_ack_single", 32'(probe_ack), 32'd0);
  endtask

  task automatic probe_oor_chk(input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    probe_x = px;
    probe_y = py;
    probe_req = 1'b1;
    @(negedge clk);
    chk("oor_ack", 32'(probe_ack), 32'd1);
    chk("oor_flag", 32'(probe_oor), 32'd1);
    chk("oor_rgb", 32'(probe_rgb), 32'd0);
    probe_req = 1'b0;
    @(negedge clk);
    chk("oor_ack_single", 32'(probe_ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    vga_in = 8'h88;
    probe_req = 1'b0;
    probe_x = '0;
    probe_y = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Acquire lock on constant 6'h3F frames.
    repeat (3) frame(6'h3F, 6'h3F, VT, -1);
    chk("lock_after_3", 32'(locked), 32'd1);
    chk("sig_3f", 32'(frame_sig), 32'(SIG_3F));
    chk("count_2", 32'(frame_count), 32'd2);
    chk("fd_pulses_2", 32'(n_fd), 32'd2);
    chk("no_errh_startup", 32'(n_eh), 32'd0);
    n_ev = 0;

    // In-range probe on a frame carrying 6'h24 at (5,7).
    fork
      frame(6'h3F, 6'h24, VT, -1);
      probe_in_range(10'd5, 10'd7, 6'h24);
    join
    chk("ack_count_1", 32'(n_ack), 32'd1);
    chk("count_3", 32'(frame_count), 32'd3);

    // Out-of-range probes, x then y.
    fork
      frame(6'h3F, 6'h3F, VT, -1);
      begin
        probe_oor_chk(10'd640, 10'd0);
        probe_oor_chk(10'd0, 10'd480);
      end
    join
    chk("ack_count_3", 32'(n_ack), 32'd3);
    chk("sig_spot", 32'(frame_sig), 32'(SIG_SPOT));
    chk("count_4", 32'(frame_count), 32'd4);

    // One 23-clock line drops lock; the frame after next relocks.
    frame(6'h3F, 6'h3F, VT, 5);
    chk("errh_one", 32'(n_eh), 32'd1);
    chk("unlock_errh", 32'(locked), 32'd0);
    chk("count_5", 32'(frame_count), 32'd5);
    fd_mark = n_fd;
    frame(6'h3F, 6'h3F, VT, -1);
    chk("no_fd_after_errh", 32'(n_fd), 32'(fd_mark));
    chk("still_track", 32'(locked), 32'd0);
    frame(6'h3F, 6'h3F, VT, -1);
    chk("relock_errh", 32'(locked), 32'd1);
    chk("count_6", 32'(frame_count), 32'd6);
    chk("sig_after_relock", 32'(frame_sig), 32'(SIG_3F));

    // Short black frame (13 lines): its signature must not be published.
    frame(6'h00, 6'h00, VT - 1, -1);
    frame(6'h00, 6'h00, VT, -1);
    chk("errv_one", 32'(n_ev), 32'd1);
    chk("unlock_errv", 32'(locked), 32'd0);
    chk("count_7", 32'(frame_count), 32'd7);
    chk("sig_kept", 32'(frame_sig), 32'(SIG_3F));
    frame(6'h00, 6'h00, VT, -1);
    chk("relock_errv", 32'(locked), 32'd1);
    chk("count_8", 32'(frame_count), 32'd8);
    chk("sig_black", 32'(frame_sig), 32'd0);
    chk("errh_unchanged", 32'(n_eh), 32'd1);

    // Reset mid-frame with a probe pending that cannot yet match.
    fork
      frame(6'h3F, 6'h3F, 5, -1);
      begin
        @(negedge clk);
        probe_x = 10'd5;
        probe_y = 10'd7;
        probe_req = 1'b1;
      end
    join
    @(negedge clk);
    rst_n = 1'b0;
    probe_req = 1'b0;
    vga_in = 8'h88;
    repeat (2) @(negedge clk);
    chk_all_zero("midreset");
    chk("probe_dropped", 32'(n_ack), 32'd3);
    rst_n = 1'b1;
    frame(6'h3F, 6'h3F, VT, -1);
    chk("post_rst_track", 32'(locked), 32'd0);
    frame(6'h3F, 6'h3F, VT, -1);
    frame(6'h3F, 6'h3F, VT, -1);
    chk("post_rst_lock", 32'(locked), 32'd1);
    chk("post_rst_count", 32'(frame_count), 32'd2);
    chk("post_rst_sig", 32'(frame_sig), 32'(SIG_3F));
    chk("post_rst_no_ack", 32'(n_ack), 32'd3);

    // All-zero bus: syncs held asserted, no edges ever seen.
    @(negedge clk);
    rst_n = 1'b0;
    vga_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fd_mark = n_fd;
    repeat (1200) @(negedge clk);
    chk("zero_bus_unlocked", 32'(locked), 32'd0);
    chk("zero_bus_no_fd", 32'(n_fd), 32'(fd_mark));
    chk("zero_bus_count", 32'(frame_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
